// File: rtl/onchip_mem_bist_master_if.sv
// rtl/onchip_mem_bist_master_if.sv - Avalon-MM s1 port bundle between the BIST master and the on-chip RAM
interface onchip_mem_bist_master_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   mem_address;
  logic [DATA_W/8-1:0] mem_byteenable;
  logic                mem_chipselect;
  logic                mem_write;
  logic [DATA_W-1:0]   mem_writedata;
  logic                mem_clken;
  logic [DATA_W-1:0]   mem_readdata;

  modport master (
    output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
    input  mem_readdata
  );

  modport slave (
    input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
    output mem_readdata
  );
endinterface

// File: rtl/onchip_mem_bist_master.sv
// rtl/onchip_mem_bist_master.sv - fill/check BIST master for the single-port on-chip RAM
// Optional: define ONCHIP_MEM_BIST_HALT_ON_ERR_EN to stop a check run at the first mismatch.
module onchip_mem_bist_master #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 10240,
  parameter int ERR_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       word_count,
  input  logic [DATA_W-1:0]     seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  onchip_mem_bist_master_if.master mem
);
  typedef enum logic [2:0] {IDLE, FILL, READ, DRAIN, DONE} state_t;

  localparam logic [ADDR_W:0]   DEPTH_N = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W:0]     n_q, cnt_q, n_clamp;
  logic [ADDR_W-1:0]   base_q, addr_q, exp_addr_q, base_mod, addr_inc;
  logic [DATA_W-1:0]   seed_q, pat_q, exp_data_q;
  logic                chk_q, cmp_valid_q, clken_q;
  logic                accept, last, mismatch;

  // A single subtraction is enough because the address space is less than twice DEPTH.
  assign n_clamp  = (word_count > DEPTH_N) ? DEPTH_N : word_count;
  assign base_mod = (base_addr >= DEPTH_A) ? base_addr - DEPTH_A : base_addr;
  assign accept   = start && (mode != 2'b00) && (n_clamp != '0);
  assign last     = (cnt_q == n_q - (ADDR_W+1)'(1));
  assign addr_inc = (addr_q == LAST_A) ? '0 : addr_q + ADDR_W'(1);
  assign mismatch = cmp_valid_q && (mem.mem_readdata != exp_data_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = accept ? (mode[0] ? FILL : READ) : DONE;
      FILL:    if (last) state_d = chk_q ? READ : DONE;
      READ:    if (last) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef ONCHIP_MEM_BIST_HALT_ON_ERR_EN
    if ((state_q == READ || state_q == DRAIN) && mismatch) state_d = DONE;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_q            <= '0;
      cnt_q          <= '0;
      base_q         <= '0;
      addr_q         <= '0;
      exp_addr_q     <= '0;
      seed_q         <= '0;
      pat_q          <= '0;
      exp_data_q     <= '0;
      chk_q          <= 1'b0;
      cmp_valid_q    <= 1'b0;
      clken_q        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      pass           <= 1'b0;
    end else begin
      clken_q     <= 1'b1;
      // Read data returns one cycle later; a halt discards whatever is still in flight.
      cmp_valid_q <= (state_q == READ) && (state_d != DONE);
      exp_data_q  <= pat_q;
      exp_addr_q  <= addr_q;

      if (state_q == IDLE && start) begin
        err_count      <= '0;
        first_err_addr <= '0;
        pass           <= ~accept;
        n_q            <= n_clamp;
        base_q         <= base_mod;
        seed_q         <= seed;
        chk_q          <= mode[1];
        cnt_q          <= '0;
        addr_q         <= base_mod;
        pat_q          <= seed;
      end else if (state_q == FILL || state_q == READ) begin
        if (last) begin
          cnt_q  <= '0;
          addr_q <= base_q;
          pat_q  <= seed_q;
        end else begin
          cnt_q  <= cnt_q + (ADDR_W+1)'(1);
          addr_q <= addr_inc;
          pat_q  <= pat_q + DATA_W'(1);
        end
      end

      if (mismatch) begin
        if (err_count != '1) err_count <= err_count + ERR_W'(1);
        if (err_count == '0) first_err_addr <= exp_addr_q;
      end

      if (state_d == DONE && state_q != IDLE && state_q != DONE)
        pass <= (err_count == '0) && !mismatch;
    end
  end

  assign busy = (state_q == FILL) || (state_q == READ) || (state_q == DRAIN);
  assign done = (state_q == DONE);

  assign mem.mem_chipselect = (state_q == FILL) || (state_q == READ);
  assign mem.mem_write      = (state_q == FILL);
  assign mem.mem_address    = mem.mem_chipselect ? addr_q : '0;
  assign mem.mem_byteenable = mem.mem_chipselect ? '1 : '0;
  assign mem.mem_writedata  = mem.mem_write ? pat_q : '0;
  assign mem.mem_clken      = clken_q;
endmodule

// File: doc/onchip_mem_bist_master.md
Name: onchip_mem_bist_master

Overview:
- Sequential Avalon-MM master that sits directly upstream of the 32-bit single-port on-chip RAM (10240 words, 14-bit word address) and drives its s1 slave port.
- On command, fills a word range with a deterministic pattern, reads it back, or does both, and reports pass/fail with error statistics.
- Used for power-on memory test and board bring-up; when idle it leaves the slave port quiescent.

Parameters:
- ADDR_W, 14, word address width of the RAM port
- DATA_W, 32, data width; byteenable width is DATA_W/8
- DEPTH, 10240, number of words; address wrap point
- ERR_W, 16, width of the saturating error counter

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle command strobe; sampled only in IDLE
- mode  in  2  01=fill only, 10=check only, 11=fill+check, 00=no-op
- base_addr  in  ADDR_W  first word address
- word_count  in  ADDR_W+1  words to process; values above DEPTH clamp to DEPTH
- seed  in  DATA_W  pattern seed
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse
- pass  out  1  1 when the last run had zero mismatches; held until next start
- err_count  out  ERR_W  mismatch count, saturates at all-ones
- first_err_addr  out  ADDR_W  address of first mismatch; valid when err_count != 0
- mem_address  out  ADDR_W  to RAM address
- mem_byteenable  out  DATA_W/8  to RAM byteenable; all ones when chipselect is high
- mem_chipselect  out  1  to RAM chipselect
- mem_write  out  1  to RAM write
- mem_writedata  out  DATA_W  to RAM writedata
- mem_clken  out  1  to RAM clken
- mem_readdata  in  DATA_W  from RAM readdata; valid 1 cycle after a read is issued

Behaviour:
- Reset (async assert, sync release) values: busy=0, done=0, pass=0, err_count=0, first_err_addr=0, all mem_* outputs 0 (including mem_clken). All internal state returns to IDLE.
- Reset during a run aborts it with no done pulse; RAM contents are undefined afterwards.
- mem_clken=1 in every cycle out of reset. The RAM read latency is fixed at 1 cycle; there is no waitrequest.
- Pattern: the word at index i (0..N-1) is seed + i, modulo 2^DATA_W.
- Address: addr(i) = (base_addr + i) mod DEPTH. The address wraps from DEPTH-1 to 0. A base_addr >= DEPTH is reduced mod DEPTH.
- FSM states are IDLE, FILL, READ, DRAIN, DONE.
- IDLE: start with mode != 00 and N=clamped word_count > 0 is accepted.
  - On accept: clear err_count and first_err_addr, set pass=0, set busy=1 next cycle.
  - Next state is FILL if mode[0]=1, otherwise READ.
- start with N=0 or mode=00: go directly to DONE. done pulses the next cycle with pass=1 and err_count=0.
- start while busy is ignored.
- FILL: one write per cycle (chipselect=1, write=1) for N cycles.
  - Then go to READ if mode[1]=1, otherwise DONE.
- READ: one read per cycle (chipselect=1, write=0) for N cycles, then DRAIN.
  - The expected word and address are pipelined 1 cycle and compared against mem_readdata in the following cycle.
- DRAIN: chipselect=0; the final compare happens here; then go to DONE.
- Mismatch handling:
  - err_count increments, saturating.
  - On the first mismatch only, first_err_addr captures the address of the failing word.
- DONE: done=1 for one cycle, busy=0, pass=(err_count==0). Next state is IDLE.
- Latency (start sampled at cycle 0): done is at cycle N+1 (fill), N+2 (check), or 2N+2 (fill+check).

Optional Feature:
- Macro: ONCHIP_MEM_BIST_HALT_ON_ERR_EN.
  - Defined: the first mismatch ends READ/DRAIN immediately and goes to DONE. Outstanding reads are discarded, so err_count=1 and pass=0.
  - Undefined: all N words are always checked, and err_count reports the total, saturating.

Test Plan:
- mode=11, base=0, N=16, seed=0xA5A50000, ideal RAM model -> 16 writes with data 0xA5A50000..0xA5A5000F, done at cycle 34, pass=1, err_count=0.
- mode=11, base=10238, N=4 -> addresses 10238, 10239, 0, 1 in both phases; pass=1.
- mode=11, N=8, RAM model flips bit 0 of the word at address 5 on read -> err_count=1, first_err_addr=5, pass=0. With HALT_ON_ERR_EN, done occurs right after the failing compare instead.
- N=0 with mode=11, and N=8 with mode=00 -> no chipselect ever asserted, done one cycle after start, pass=1.
- start re-pulsed mid-FILL, and N=20000 -> the second start is ignored; N clamps to 10240 (10240 writes).
- reset_n dropped mid-READ -> all outputs immediately 0, no done pulse; a new run afterwards behaves normally.
